// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package mdio_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StPre,
      StSt,
      StOp,
      StPhyad,
      StRegad,
      StTa,
      StData,
      StDone
   } mdio_state_e;

   localparam logic [1:0] ST_CODE = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] TA_WR   = 2'b10;

   localparam int unsigned PRE_LEN   = 32;
   localparam int unsigned FRAME_LEN = 64;

   // First bit index of each frame field
   localparam logic [5:0] IDX_ST    = 6'(PRE_LEN);
   localparam logic [5:0] IDX_OP    = 6'd34;
   localparam logic [5:0] IDX_PHYAD = 6'd36;
   localparam logic [5:0] IDX_REGAD = 6'd41;
   localparam logic [5:0] IDX_TA    = 6'd46;
   localparam logic [5:0] IDX_TA2   = 6'd47;
   localparam logic [5:0] IDX_DATA  = 6'd48;
   localparam logic [5:0] IDX_LAST  = 6'(FRAME_LEN - 1);

   // Frame field that owns a given bit index
   function automatic mdio_state_e idx_to_state(input logic [5:0] idx);
      if (idx < IDX_ST)         return StPre;
      else if (idx < IDX_OP)    return StSt;
      else if (idx < IDX_PHYAD) return StOp;
      else if (idx < IDX_REGAD) return StPhyad;
      else if (idx < IDX_TA)    return StRegad;
      else if (idx < IDX_DATA)  return StTa;
      else                      return StData;
   endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Command/response handshake between the PHY management controller and the MDIO master.
interface mdio_master_if;
   logic        op_exec;
   logic        op_rh_wl;
   logic [4:0]  op_addr;
   logic [15:0] op_wr_data;
   logic        op_done;
   logic [15:0] op_rd_data;
   logic        op_rd_ack;

   modport master (
      output op_exec, op_rh_wl, op_addr, op_wr_data,
      input  op_done, op_rd_data, op_rd_ack
   );

   modport slave (
      input  op_exec, op_rh_wl, op_addr, op_wr_data,
      output op_done, op_rd_data, op_rd_ack
   );
endinterface

// File: rtl/mdio_clk_gen.sv
// MDC divider: free-runs only while a frame is in flight and emits per-bit timing ticks.
module mdio_clk_gen #(
   parameter int unsigned CLK_DIV = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic mdc,
   output logic drive_tick,
   output logic sample_tick,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          mdc_q;

   // Counter wraps within a bit period and parks at zero when idle
   always_comb begin
      cnt_d = '0;
      if (run) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // mdc is registered from the next count so it tracks cnt without decode glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= (cnt_d >= HALF);
      end
   end

   assign mdc         = mdc_q;
   assign drive_tick  = run && (cnt_q == '0);
   assign sample_tick = run && (cnt_q == HALF);
   assign bit_end     = run && (cnt_q == LAST);

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: serialises one read/write frame per command onto MDC/MDIO.
// Optional build macro MDIO_PRE_SUPPRESS_EN skips the 32-bit preamble.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 20,
   parameter logic [4:0]  PHY_ADDR = 5'b00001
) (
   input  logic           clk,
   input  logic           rst_n,
   mdio_master_if.slave   op,
   output logic           mdc,
   output logic           mdio_o,
   output logic           mdio_oe,
   input  logic           mdio_i
);

`ifdef MDIO_PRE_SUPPRESS_EN
   localparam logic [5:0] START_IDX = IDX_ST;
`else
   localparam logic [5:0] START_IDX = 6'd0;
`endif

   mdio_state_e state_q, state_d;
   logic [5:0]  bit_idx_q, bit_idx_d;
   logic        rd_q, rd_d;
   logic [31:0] tx_sr_q, tx_sr_d;
   logic [15:0] rx_sr_q, rx_sr_d;
   logic        ta_ack_q, ta_ack_d;
   logic        mdio_o_q, mdio_o_d;
   logic        mdio_oe_q, mdio_oe_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        rd_ack_q, rd_ack_d;

   logic run, drive_tick, sample_tick, bit_end;

   assign run = (state_q != StIdle) && (state_q != StDone);

   mdio_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .mdc         (mdc),
      .drive_tick  (drive_tick),
      .sample_tick (sample_tick),
      .bit_end     (bit_end)
   );

   // Next-state: command capture, bit drive/sample and field sequencing
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      rd_d      = rd_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      ta_ack_d  = ta_ack_q;
      mdio_o_d  = mdio_o_q;
      mdio_oe_d = mdio_oe_q;
      rd_data_d = rd_data_q;
      rd_ack_d  = rd_ack_q;

      case (state_q)
         StIdle: begin
            if (op.op_exec) begin
               rd_d      = op.op_rh_wl;
               // Reads load all-ones for TA/DATA so a released line idles high
               tx_sr_d   = {ST_CODE, op.op_rh_wl ? OP_RD : OP_WR, PHY_ADDR, op.op_addr,
                            op.op_rh_wl ? 2'b11 : TA_WR,
                            op.op_rh_wl ? 16'hFFFF : op.op_wr_data};
               bit_idx_d = START_IDX;
               state_d   = idx_to_state(START_IDX);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            if (drive_tick) begin
               if (bit_idx_q < IDX_ST) begin
                  mdio_o_d  = 1'b1;
                  mdio_oe_d = 1'b1;
               end else begin
                  mdio_o_d  = tx_sr_q[31];
                  tx_sr_d   = {tx_sr_q[30:0], 1'b1};
                  mdio_oe_d = !(rd_q && (bit_idx_q >= IDX_TA));
               end
            end

            if (sample_tick && rd_q) begin
               if (bit_idx_q == IDX_TA2) begin
                  ta_ack_d = mdio_i;
               end
               if (bit_idx_q >= IDX_DATA) begin
                  rx_sr_d = {rx_sr_q[14:0], mdio_i};
               end
            end

            if (bit_end) begin
               if (bit_idx_q == IDX_LAST) begin
                  state_d   = StDone;
                  mdio_o_d  = 1'b1;
                  mdio_oe_d = 1'b0;
                  // Results become visible together with op_done
                  if (rd_q) begin
                     rd_data_d = rx_sr_q;
                     rd_ack_d  = ta_ack_q;
                  end else begin
                     rd_ack_d  = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 6'd1;
                  state_d   = idx_to_state(bit_idx_q + 6'd1);
               end
            end
         end
      endcase
   end

   // State register; async reset abandons any frame without a completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bit_idx_q <= '0;
         rd_q      <= 1'b0;
         tx_sr_q   <= '1;
         rx_sr_q   <= '0;
         ta_ack_q  <= 1'b0;
         mdio_o_q  <= 1'b1;
         mdio_oe_q <= 1'b0;
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         rd_q      <= rd_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         ta_ack_q  <= ta_ack_d;
         mdio_o_q  <= mdio_o_d;
         mdio_oe_q <= mdio_oe_d;
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
      end
   end

   assign mdio_o        = mdio_o_q;
   assign mdio_oe       = mdio_oe_q;
   assign op.op_done    = (state_q == StDone);
   assign op.op_rd_data = rd_data_q;
   assign op.op_rd_ack  = rd_ack_q;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: PHY model on MDC/MDIO, expected frames queued per command.
module tb_mdio_master;

   localparam int unsigned CLK_DIV  = 20;
   localparam logic [4:0]  PHY_ADDR = 5'b00001;
`ifdef MDIO_PRE_SUPPRESS_EN
   localparam int FL = 32;
`else
   localparam int FL = 64;
`endif
   localparam int OFF = 64 - FL;

   typedef struct {
      logic [63:0] frame;
      logic [63:0] oe;
      logic [63:0] mask_o;
      logic [63:0] mask_v;
      logic [15:0] rd_data;
      logic        rd_ack;
      int          start;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mdc, mdio_o, mdio_oe, mdio_i;

   always #5 clk = ~clk;

   mdio_master_if op_if ();

   mdio_master #(
      .CLK_DIV  (CLK_DIV),
      .PHY_ADDR (PHY_ADDR)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .op      (op_if),
      .mdc     (mdc),
      .mdio_o  (mdio_o),
      .mdio_oe (mdio_oe),
      .mdio_i  (mdio_i)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          rise_cnt = 0;
   int          fall_cnt = 0;
   logic        mdc_prev = 1'b0;
   logic [63:0] cap_o = '0;
   logic [63:0] cap_oe = '0;
   exp_t        sb[$];
   logic        phy_rd = 1'b0;
   logic        phy_present = 1'b0;
   logic [15:0] phy_data = '0;
   logic [15:0] last_rd = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // PHY: changes its output after each MDC fall; fc equals the current bit number
   function automatic logic phy_bit(input int fc, input logic rd, input logic pres,
                                    input logic [15:0] d);
      int p;
      p = fc + OFF;
      if (!rd || !pres) return 1'b1;
      if (p == 47) return 1'b0;
      if (p >= 48 && p <= 63) return d[63 - p];
      return 1'b1;
   endfunction

   always_comb mdio_i = phy_bit(fall_cnt, phy_rd, phy_present, phy_data);

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: capture the frame at MDC rises, score each op_done against the queue head
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         rise_cnt = 0;
         fall_cnt = 0;
         cap_o    = '0;
         cap_oe   = '0;
         mdc_prev = mdc;
      end else begin
         if (mdc && !mdc_prev) begin
            if (rise_cnt + OFF < 64) begin
               cap_o[63 - (rise_cnt + OFF)]  = mdio_o;
               cap_oe[63 - (rise_cnt + OFF)] = mdio_oe;
            end
            rise_cnt++;
         end
         if (!mdc && mdc_prev) fall_cnt++;
         mdc_prev = mdc;
         if (op_if.op_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("latency", 64'(cyc - e.start), 64'(FL * CLK_DIV + 1));
               check("frame_bits", cap_o & e.mask_o, e.frame & e.mask_o);
               check("oe_bits", cap_oe & e.mask_v, e.oe & e.mask_v);
               check("bit_count", 64'(rise_cnt), 64'(FL));
               check("rd_data", 64'(op_if.op_rd_data), 64'(e.rd_data));
               check("rd_ack", 64'(op_if.op_rd_ack), 64'(e.rd_ack));
            end
            rise_cnt = 0;
            fall_cnt = 0;
            cap_o    = '0;
            cap_oe   = '0;
         end
      end
   end

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < FL * CLK_DIV + 100) begin
         @(posedge clk);
         t++;
      end
      repeat (5) @(posedge clk);
      check("done_pulses", 64'(done_cnt - d0), 64'd1);
   endtask

   // One command; pulse_bit >= 0 fires a stray op_exec during that frame bit
   task automatic run_txn(input logic rd, input logic [4:0] addr, input logic [15:0] wdata,
                          input logic present, input logic [15:0] pdata, input int pulse_bit);
      exp_t        e;
      logic [63:0] all1;
      logic [63:0] rd_mask;
      int          d0;
      all1    = '1;
      rd_mask = {{46{1'b1}}, {18{1'b0}}};
      e.frame  = {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, PHY_ADDR, addr, 2'b10, wdata};
      e.oe     = rd ? rd_mask : all1;
      e.mask_v = all1 >> OFF;
      e.mask_o = rd ? (e.mask_v & rd_mask) : e.mask_v;
      if (rd) begin
         e.rd_data = present ? pdata : 16'hFFFF;
         e.rd_ack  = !present;
         last_rd   = e.rd_data;
      end else begin
         e.rd_data = last_rd;
         e.rd_ack  = 1'b0;
      end
      phy_rd      = rd;
      phy_present = present;
      phy_data    = pdata;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      op_if.op_rh_wl   = rd;
      op_if.op_addr    = addr;
      op_if.op_wr_data = wdata;
      op_if.op_exec    = 1'b1;
      e.start = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      op_if.op_exec    = 1'b0;
      op_if.op_rh_wl   = !rd;
      op_if.op_addr    = ~addr;
      op_if.op_wr_data = ~wdata;
      if (pulse_bit >= 0) begin
         repeat ((pulse_bit - OFF) * CLK_DIV + 3) @(posedge clk);
         #1;
         op_if.op_rh_wl   = 1'b1;
         op_if.op_addr    = 5'h1F;
         op_if.op_exec    = 1'b1;
         @(posedge clk);
         #1;
         op_if.op_exec    = 1'b0;
      end
      wait_done(d0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_done"}, 64'(op_if.op_done), 64'd0);
      check({tag, "_rd_data"}, 64'(op_if.op_rd_data), 64'h0);
      check({tag, "_rd_ack"}, 64'(op_if.op_rd_ack), 64'd0);
      check({tag, "_mdc"}, 64'(mdc), 64'd0);
      check({tag, "_mdio_o"}, 64'(mdio_o), 64'd1);
      check({tag, "_mdio_oe"}, 64'(mdio_oe), 64'd0);
   endtask

   initial begin
      int d0;
      op_if.op_exec    = 1'b0;
      op_if.op_rh_wl   = 1'b0;
      op_if.op_addr    = '0;
      op_if.op_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      run_txn(1'b0, 5'h00, 16'h9140, 1'b1, 16'h0000, -1);
      run_txn(1'b1, 5'h01, 16'h0000, 1'b1, 16'h796D, -1);
      run_txn(1'b1, 5'h11, 16'h0000, 1'b0, 16'h0000, -1);
      run_txn(1'b0, 5'h04, 16'h01E1, 1'b1, 16'h0000, (OFF > 10) ? OFF + 2 : 10);

      // Abort a read at frame bit 40 with async reset
      phy_rd = 1'b1;
      phy_present = 1'b1;
      phy_data = 16'h1234;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      op_if.op_rh_wl = 1'b1;
      op_if.op_addr  = 5'h01;
      op_if.op_exec  = 1'b1;
      @(posedge clk);
      #1;
      op_if.op_exec  = 1'b0;
      repeat ((40 - OFF) * CLK_DIV + 3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check_reset_outputs("midreset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_rd = '0;
      repeat (FL * CLK_DIV + 50) @(posedge clk);
      check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);

      run_txn(1'b1, 5'h01, 16'h0000, 1'b1, 16'hA5C3, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
